div_arbiter: RTL and testbench

DIV_ARBITER -- requirements
Module: div_arbiter

---
 rtl/div_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_div_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin front end that shares one successive-approximation
// divider core among N_REQ requesters, one operation in flight at a time.
// After reset the block holds off for DRAIN_CYCLES clocks so that any result
// still travelling through the core from before the reset is swallowed.
// Optional build macro DIV_ARBITER_ZERO_BYPASS_EN: divisor-0 requests skip the
// core and are answered directly with an all-ones quotient.

module div_arbiter #(
  parameter int N_REQ        = 4,
  parameter int DIVIDEND_W   = 32,
  parameter int DIVISOR_W    = 21,
  parameter int QUOTIENT_W   = 32,
  parameter int DRAIN_CYCLES = 194
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ*DIVIDEND_W-1:0] req_dividend,
  input  logic [N_REQ*DIVISOR_W-1:0]  req_divisor,
  output logic [N_REQ-1:0]            resp_valid,
  output logic [QUOTIENT_W-1:0]       resp_quotient,
  output logic                        div_start,
  output logic [DIVIDEND_W-1:0]       div_dividend,
  output logic [DIVISOR_W-1:0]        div_divisor,
  input  logic [QUOTIENT_W-1:0]       div_quotient,
  input  logic                        div_qv,
  output logic                        busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_DRAIN,
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        drainCnt_q, drainCnt_d;
  logic [PTR_W-1:0]        rrPtr_q, rrPtr_d;
  logic [PTR_W-1:0]        grant_q, grant_d;
  logic [DIVIDEND_W-1:0]   dividend_q, dividend_d;
  logic [DIVISOR_W-1:0]    divisor_q, divisor_d;
  logic [QUOTIENT_W-1:0]   capture_q, capture_d;
  logic [QUOTIENT_W-1:0]   respQuot_q, respQuot_d;
  logic                    qvSeen_q, qvSeen_d;

  logic [DIVIDEND_W-1:0]   slotDividend [N_REQ];
  logic [DIVISOR_W-1:0]    slotDivisor  [N_REQ];
  logic                    anyReq;
  logic [PTR_W-1:0]        pickIdx;
  logic [PTR_W-1:0]        scanIdx;

  for (genvar k = 0; k < N_REQ; k++) begin : g_slot
    assign slotDividend[k] = req_dividend[k*DIVIDEND_W +: DIVIDEND_W];
    assign slotDivisor[k]  = req_divisor[k*DIVISOR_W +: DIVISOR_W];
  end

  assign busy          = (state_q != S_IDLE);
  assign div_dividend  = dividend_q;
  assign div_divisor   = divisor_q;
  assign resp_quotient = respQuot_q;

  // Round-robin pick: first requesting slot at or after rrPtr_q, wrapping.
  always_comb begin
    anyReq  = 1'b0;
    pickIdx = rrPtr_q;
    scanIdx = rrPtr_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (!anyReq && req_valid[scanIdx]) begin
        anyReq  = 1'b1;
        pickIdx = scanIdx;
      end
      scanIdx = (scanIdx == PTR_LAST) ? '0 : scanIdx + 1'b1;
    end
  end

  // Next-state and output decode; the core result is captured in WAIT and
  // moved to the response bus one cycle later as the state enters RESP.
  always_comb begin
    state_d    = state_q;
    drainCnt_d = drainCnt_q;
    rrPtr_d    = rrPtr_q;
    grant_d    = grant_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    capture_d  = capture_q;
    respQuot_d = respQuot_q;
    qvSeen_d   = qvSeen_q;
    req_ready  = '0;
    resp_valid = '0;
    div_start  = 1'b0;

    case (state_q)
      S_DRAIN: begin
        if (drainCnt_q == CNT_LAST) begin
          state_d = S_IDLE;
        end else begin
          drainCnt_d = drainCnt_q + 1'b1;
        end
      end

      S_IDLE: begin
        if (anyReq) begin
          req_ready[pickIdx] = 1'b1;
          grant_d    = pickIdx;
          dividend_d = slotDividend[pickIdx];
          divisor_d  = slotDivisor[pickIdx];
          qvSeen_d   = 1'b0;
`ifdef DIV_ARBITER_ZERO_BYPASS_EN
          if (slotDivisor[pickIdx] == '0) begin
            state_d    = S_RESP;
            respQuot_d = '1;
          end else begin
            state_d = S_ISSUE;
          end
`else
          state_d = S_ISSUE;
`endif
        end
      end

      S_ISSUE: begin
        div_start = 1'b1;
        state_d   = S_WAIT;
      end

      S_WAIT: begin
        if (qvSeen_q) begin
          qvSeen_d   = 1'b0;
          respQuot_d = capture_q;
          state_d    = S_RESP;
        end else if (div_qv) begin
          capture_d = div_quotient;
          qvSeen_d  = 1'b1;
        end
      end

      S_RESP: begin
        resp_valid[grant_q] = 1'b1;
        rrPtr_d = (grant_q == PTR_LAST) ? '0 : grant_q + 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_DRAIN;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_DRAIN;
      drainCnt_q <= '0;
      rrPtr_q    <= '0;
      grant_q    <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      capture_q  <= '0;
      respQuot_q <= '0;
      qvSeen_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      drainCnt_q <= drainCnt_d;
      rrPtr_q    <= rrPtr_d;
      grant_q    <= grant_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      capture_q  <= capture_d;
      respQuot_q <= respQuot_d;
      qvSeen_q   <= qvSeen_d;
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: directed bench for div_arbiter with a behavioural divider
// core and a transaction-level arbiter model checked every cycle.
// Honours DIV_ARBITER_ZERO_BYPASS_EN for the divisor-0 scenario.

module tb_div_arbiter;

  localparam int N        = 4;
  localparam int DW       = 32;
  localparam int SW       = 21;
  localparam int QW       = 32;
  localparam int DRAIN    = 194;
  localparam int CORE_LAT = 6;
  localparam logic [31:0] ZERO_Q = 32'h0BAD_0000;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_dividend = '0;
  logic [N*SW-1:0] req_divisor = '0;
  logic [N-1:0]    resp_valid;
  logic [QW-1:0]   resp_quotient;
  logic            div_start;
  logic [DW-1:0]   div_dividend;
  logic [SW-1:0]   div_divisor;
  logic [QW-1:0]   div_quotient = '0;
  logic            div_qv;
  logic            busy;
  logic            coreQv = 1'b0;
  logic            strayQv = 1'b0;

  assign div_qv = coreQv | strayQv;

  always #5 clk = ~clk;

  div_arbiter #(
    .N_REQ(N), .DIVIDEND_W(DW), .DIVISOR_W(SW), .QUOTIENT_W(QW), .DRAIN_CYCLES(DRAIN)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .resp_valid(resp_valid), .resp_quotient(resp_quotient),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_qv(div_qv), .busy(busy)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model state
  int          now = 0;
  int          sinceRel = 0;
  int          ptrModel = 0;
  bit          pendValid = 1'b0;
  bit          pendBypass = 1'b0;
  int          pendSlot = 0;
  int          pendReady = 0;
  int          pendResp = 0;
  logic [31:0] pendDvd = '0;
  logic [20:0] pendDvs = '0;
  logic [31:0] pendQ = '0;
  int          startCount = 0;
  int          lastGrantSinceRel = 0;
  logic [31:0] opDvd [N];
  logic [20:0] opDvs [N];
  int          grantLog[$];
  int          respSlotLog[$];
  logic [31:0] respQLog[$];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, actual, expected);
    end
  endtask

  function automatic int firstFrom(input int p, input logic [N-1:0] v);
    for (int i = 0; i < N; i++) begin
      int s;
      s = (p + i) % N;
      if (v[s]) return s;
    end
    return -1;
  endfunction

  function automatic logic [31:0] expectQuot(input logic [31:0] a, input logic [20:0] b);
    if (b == 0) begin
`ifdef DIV_ARBITER_ZERO_BYPASS_EN
      return 32'hFFFF_FFFF;
`else
      return ZERO_Q;
`endif
    end
    return a / b;
  endfunction

  // Behavioural divider core: answers CORE_LAT cycles after a start pulse and
  // keeps going through a reset, like the real core would.
  initial begin
    logic [31:0] cd;
    logic [20:0] cs;
    forever begin
      @(negedge clk);
      if (div_start) begin
        cd = div_dividend;
        cs = div_divisor;
        repeat (CORE_LAT) @(posedge clk);
        #1;
        coreQv = 1'b1;
        div_quotient = (cs == 0) ? ZERO_Q : cd / cs;
        @(posedge clk);
        #1;
        coreQv = 1'b0;
      end
    end
  end

  // Per-cycle compare against the transaction model.
  initial begin
    logic [N-1:0] expReady;
    logic [N-1:0] expResp;
    bit           drained;
    bit           expStart;
    int           g;
    forever begin
      @(negedge clk);
      now++;
      if (!rst_n) begin
        checkOutput("reset req_ready", req_ready, 0);
        checkOutput("reset resp_valid", resp_valid, 0);
        checkOutput("reset div_start", div_start, 0);
        checkOutput("reset busy", busy, 1);
        checkOutput("reset resp_quotient", resp_quotient, 0);
        checkOutput("reset div_dividend", div_dividend, 0);
        checkOutput("reset div_divisor", div_divisor, 0);
        pendValid = 1'b0;
        ptrModel  = 0;
        sinceRel  = 0;
      end else begin
        sinceRel++;
        drained = (sinceRel > DRAIN);
        if (div_start) startCount++;
        checkOutput("busy", busy, (pendValid || !drained));
        expReady = '0;
        g = -1;
        if (drained && !pendValid && (|req_valid)) begin
          g = firstFrom(ptrModel, req_valid);
          expReady[g] = 1'b1;
        end
        checkOutput("req_ready", req_ready, expReady);
        expStart = pendValid && !pendBypass && (now == pendReady + 1);
        checkOutput("div_start", div_start, expStart);
        if (pendValid && !pendBypass && now > pendReady) begin
          checkOutput("div_dividend", div_dividend, pendDvd);
          checkOutput("div_divisor", div_divisor, pendDvs);
        end
        if (pendValid && now == pendResp) begin
          expResp = '0;
          expResp[pendSlot] = 1'b1;
          checkOutput("resp_valid", resp_valid, expResp);
          checkOutput("resp_quotient", resp_quotient, pendQ);
          respSlotLog.push_back(pendSlot);
          respQLog.push_back(resp_quotient);
          ptrModel  = (pendSlot + 1) % N;
          pendValid = 1'b0;
        end else begin
          checkOutput("resp_valid quiet", resp_valid, 0);
        end
        if (g >= 0) begin
          pendValid  = 1'b1;
          pendSlot   = g;
          pendReady  = now;
          pendDvd    = opDvd[g];
          pendDvs    = opDvs[g];
          pendQ      = expectQuot(opDvd[g], opDvs[g]);
`ifdef DIV_ARBITER_ZERO_BYPASS_EN
          pendBypass = (opDvs[g] == 0);
`else
          pendBypass = 1'b0;
`endif
          pendResp   = pendBypass ? now + 1 : now + CORE_LAT + 3;
          grantLog.push_back(g);
          lastGrantSinceRel = sinceRel;
        end
      end
    end
  end

  task automatic setOperand(input int slot, input logic [31:0] dvd, input logic [20:0] dvs);
    opDvd[slot] = dvd;
    opDvs[slot] = dvs;
    req_dividend[slot*DW +: DW] = dvd;
    req_divisor[slot*SW +: SW]  = dvs;
  endtask

  task automatic waitGrants(input int target, input int bound);
    int i;
    i = 0;
    while (grantLog.size() < target && i < bound) begin
      @(posedge clk);
      #1;
      i++;
    end
    if (grantLog.size() < target) checkOutput("grant timeout", grantLog.size(), target);
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 200 && pendValid; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("completion timeout", pendValid, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int slot, input logic [31:0] dvd, input logic [20:0] dvs);
    int g0;
    setOperand(slot, dvd, dvs);
    g0 = grantLog.size();
    req_valid[slot] = 1'b1;
    waitGrants(g0 + 1, 400);
    req_valid[slot] = 1'b0;
    waitIdle();
  endtask

  task automatic expectResp(input string name, input int idx, input int slot, input logic [31:0] q);
    if (idx < respQLog.size()) begin
      checkOutput({name, " slot"}, respSlotLog[idx], slot);
      checkOutput({name, " quotient"}, respQLog[idx], q);
    end else begin
      checkOutput({name, " missing"}, respQLog.size(), idx + 1);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int r0, s0, g0;
    int expGrant [5];
    logic [31:0] expQ [5];
    expGrant = '{0, 1, 2, 3, 0};
    expQ     = '{32'd33, 32'd9, 32'd4294967, 32'd1, 32'd33};
    for (int k = 0; k < N; k++) setOperand(k, '0, 21'd1);

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (DRAIN + 3) @(posedge clk);
    #1;
    checkOutput("idle after drain busy", busy, 0);

    $display("[TB] single request");
    r0 = respQLog.size();
    s0 = startCount;
    applyStimulus(1, 32'd1000, 21'd7);
    expectResp("single", r0, 1, 32'd142);
    checkOutput("single start pulses", startCount - s0, 1);

    $display("[TB] contention");
    r0 = respQLog.size();
    applyStimulus(3, 32'd999, 21'd1000);
    expectResp("wrap slot3", r0, 3, 32'd0);
    setOperand(0, 32'd100, 21'd3);
    setOperand(1, 32'd81, 21'd9);
    setOperand(2, 32'hFFFF_FFFF, 21'd1000);
    setOperand(3, 32'd77, 21'd77);
    g0 = grantLog.size();
    r0 = respQLog.size();
    req_valid = '1;
    waitGrants(g0 + 5, 400);
    req_valid = '0;
    waitIdle();
    for (int k = 0; k < 5; k++) begin
      if (g0 + k < grantLog.size()) checkOutput("rotation order", grantLog[g0 + k], expGrant[k]);
      else checkOutput("rotation missing", grantLog.size(), g0 + k + 1);
      expectResp("rotation", r0 + k, expGrant[k], expQ[k]);
    end

    $display("[TB] stray div_qv in IDLE");
    r0 = respQLog.size();
    strayQv = 1'b1;
    @(posedge clk);
    #1;
    strayQv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("stray qv resp count", respQLog.size(), r0);
    checkOutput("stray qv busy", busy, 0);
    applyStimulus(2, 32'd60, 21'd4);
    expectResp("after stray", r0, 2, 32'd15);

    $display("[TB] reset during WAIT");
    setOperand(0, 32'd5000, 21'd3);
    g0 = grantLog.size();
    req_valid[0] = 1'b1;
    waitGrants(g0 + 1, 50);
    req_valid[0] = 1'b0;
    for (int i = 0; i < 10 && !div_start; i++) @(negedge clk);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    r0 = respQLog.size();
    g0 = grantLog.size();
    setOperand(2, 32'd50, 21'd5);
    req_valid[2] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    waitGrants(g0 + 1, DRAIN + 20);
    req_valid[2] = 1'b0;
    checkOutput("first grant after drain cycle", lastGrantSinceRel, DRAIN + 1);
    waitIdle();
    checkOutput("post-reset resp count", respQLog.size(), r0 + 1);
    expectResp("post-reset", r0, 2, 32'd10);

    $display("[TB] zero divisor");
    r0 = respQLog.size();
    s0 = startCount;
    g0 = grantLog.size();
    setOperand(3, 32'd123, 21'd0);
    req_valid[3] = 1'b1;
    waitGrants(g0 + 1, 50);
    req_valid[3] = 1'b0;
    @(posedge clk);
    #1;
`ifdef DIV_ARBITER_ZERO_BYPASS_EN
    checkOutput("bypass quotient at ready+2", resp_quotient, 32'hFFFF_FFFF);
`endif
    waitIdle();
`ifdef DIV_ARBITER_ZERO_BYPASS_EN
    checkOutput("bypass start pulses", startCount - s0, 0);
    expectResp("zero bypass", r0, 3, 32'hFFFF_FFFF);
`else
    checkOutput("zero start pulses", startCount - s0, 1);
    expectResp("zero via core", r0, 3, ZERO_Q);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
